alu_axil_slave: RTL and testbench

AXI4-Lite responder for the simple ALU peripheral. It holds two operand registers, a control/status register and a read-only result register. It executes ALU operations on a software start command and returns register contents to the bus master. The block sits in the IP core behind the AXI interconnect port S00_AXI and is driven by the AXI VIP master in the block-design bench.

---
 rtl/alu_axil_slave.sv | 257 +++++++++++++++++++++++++
 tb/tb_alu_axil_slave.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_axil_slave.sv
// -----------------------------------------------------------------------------
// alu_axil_slave
//
// AXI4-Lite responder for the simple ALU peripheral. Four word registers:
//   0x0 OP_A   (rw, byte strobes honoured)
//   0x4 OP_B   (rw, byte strobes honoured)
//   0x8 CTRL   [2:0] OPCODE rw, [8] BUSY ro, [9] ERR ro sticky,
//              [31] START write-1 launches an operation, reads 0
//   0xC RESULT (ro; writes complete with OKAY and are dropped)
//
// A START copies OP_A, OP_B and OPCODE into execution registers, so later
// operand writes cannot disturb an operation in flight. Single-cycle ops
// finish one cycle after launch; MUL runs a 32-step shift-add.
//
// Build option: define ALU_MUL_EN to build the multiplier. Without it, a
// START with opcode 101 only sets ERR.
//
// Ports:
//   ACLK, ARESETN          clock, synchronous active-low reset
//   S_AXI_AW* / S_AXI_W*   write address / data channels (AWPROT ignored)
//   S_AXI_B*               write response, always OKAY
//   S_AXI_AR* / S_AXI_R*   read address / data channels (ARPROT ignored)
// -----------------------------------------------------------------------------
module alu_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t state_q, state_d;

  logic          aw_ready_q, bvalid_q, ar_ready_q, rvalid_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] op_a_q, op_b_q, result_q;
  logic [2:0]    opcode_q;
  logic          err_q;
  logic [DW-1:0] ea_q, eb_q;   // execution copies of the operands
  logic [2:0]    eop_q;

  logic          wr_fire, rd_fire, ctrl_wr, start_req, launch, exec_last, exec_done;
  logic [1:0]    wr_sel, rd_sel;
  logic [2:0]    opcode_nx;
  logic [DW-1:0] ctrl_rd, rd_mux, alu_out;

`ifdef ALU_MUL_EN
  logic [DW-1:0] acc_q, mul_sum;
  logic [4:0]    cnt_q;
  assign mul_sum = acc_q + (eb_q[0] ? ea_q : '0);
`endif

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0]   cur,
                                                input logic [DW-1:0]   data,
                                                input logic [DW/8-1:0] strb);
    logic [DW-1:0] r;
    r = cur;
    for (int i = 0; i < DW/8; i++)
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  assign wr_fire   = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire   = ar_ready_q & S_AXI_ARVALID;
  assign wr_sel    = S_AXI_AWADDR[3:2];
  assign rd_sel    = S_AXI_ARADDR[3:2];
  assign ctrl_wr   = wr_fire && (wr_sel == 2'd2);
  assign start_req = ctrl_wr && S_AXI_WSTRB[3] && S_AXI_WDATA[DW-1];
  // The operation uses the opcode carried by the START write itself.
  assign opcode_nx = (ctrl_wr && S_AXI_WSTRB[0]) ? S_AXI_WDATA[2:0] : opcode_q;

`ifdef ALU_MUL_EN
  assign launch    = start_req && (state_q == S_IDLE);
  assign exec_last = (eop_q != OP_MUL) || (cnt_q == 5'd31);
`else
  assign launch    = start_req && (state_q == S_IDLE) && (opcode_nx != OP_MUL);
  assign exec_last = 1'b1;
`endif

  assign ctrl_rd = {{(DW-10){1'b0}}, err_q, (state_q == S_EXEC), 5'b0, opcode_q};

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

  // ---------------------------------------------------------------- write channel
  // Ready is a one-cycle pulse; it cannot re-arm while a response is pending.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
    end else begin
      aw_ready_q <= !aw_ready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
      if (wr_fire)           bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- read channel
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    rd_mux = '0;
    case (rd_sel)
      2'd0: rd_mux = op_a_q;
      2'd1: rd_mux = op_b_q;
      2'd2: rd_mux = ctrl_rd;
      2'd3: rd_mux = result_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ar_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ar_ready_q <= !ar_ready_q && S_AXI_ARVALID && !rvalid_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- execution FSM
  always_ff @(posedge ACLK) begin
    if (!ARESETN) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    exec_done = 1'b0;
    case (state_q)
      S_IDLE: if (launch) state_d = S_EXEC;
      S_EXEC: if (exec_last) begin
        exec_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_out = '0;
    case (eop_q)
      OP_ADD: alu_out = ea_q + eb_q;
      OP_SUB: alu_out = ea_q - eb_q;
      OP_AND: alu_out = ea_q & eb_q;
      OP_OR:  alu_out = ea_q | eb_q;
      OP_XOR: alu_out = ea_q ^ eb_q;
`ifdef ALU_MUL_EN
      OP_MUL: alu_out = mul_sum;
`endif
      OP_SLL: alu_out = ea_q << eb_q[4:0];
      OP_SRL: alu_out = ea_q >> eb_q[4:0];
      default: alu_out = '0;
    endcase
  end

  // ---------------------------------------------------------------- register file
  // NOTE: every register here is a plain flop with a synchronous clear; there is
  // no RAM, so reset aborts any running operation and zeroes RESULT.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      opcode_q <= '0;
      err_q    <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      eop_q    <= '0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      if (wr_fire && wr_sel == 2'd0) op_a_q <= merge_bytes(op_a_q, S_AXI_WDATA, S_AXI_WSTRB);
      if (wr_fire && wr_sel == 2'd1) op_b_q <= merge_bytes(op_b_q, S_AXI_WDATA, S_AXI_WSTRB);
      opcode_q <= opcode_nx;

      if (launch) begin
        ea_q  <= op_a_q;
        eb_q  <= op_b_q;
        eop_q <= opcode_nx;
        err_q <= 1'b0;
`ifdef ALU_MUL_EN
        acc_q <= '0;
        cnt_q <= '0;
`endif
      end else if (start_req) begin
        // START while busy (or an unbuilt MUL) is dropped and flagged.
        err_q <= 1'b1;
      end

`ifdef ALU_MUL_EN
      // One partial product per cycle: bit cnt of B selects A << cnt.
      if (state_q == S_EXEC && eop_q == OP_MUL) begin
        acc_q <= mul_sum;
        ea_q  <= ea_q << 1;
        eb_q  <= eb_q >> 1;
        cnt_q <= cnt_q + 5'd1;
      end
`endif

      if (exec_done) result_q <= alu_out;
    end
  end

endmodule

// File: tb/tb_alu_axil_slave.sv
// -----------------------------------------------------------------------------
// tb_alu_axil_slave
//
// Self-checking bench for alu_axil_slave. A transaction-level model tracks the
// register contents and the cycle at which each launched operation completes;
// a compare process checks the DUT's response channels against it every cycle,
// and directed sequences pin known values. Honours ALU_MUL_EN.
// -----------------------------------------------------------------------------
module tb_alu_axil_slave;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        ACLK;
  logic        ARESETN;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  alu_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------- reference model
  logic [31:0] m_a, m_b, m_res, m_pend;
  logic [2:0]  m_op;
  logic        m_err, m_pv, m_bv;
  longint      m_cyc, m_done;
  logic [31:0] m_rq[$];

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a * b;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] cur, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (cur & ~mask) | (d & mask);
  endfunction

  // Model state is "as seen during cycle m_cyc"; it is advanced at each edge.
  initial begin : model
    logic [31:0] rv;
    logic        busy;
    m_cyc = 0; m_done = 0; m_pv = 1'b0; m_bv = 1'b0;
    m_a = '0; m_b = '0; m_res = '0; m_pend = '0; m_op = '0; m_err = 1'b0;
    forever begin
      @(posedge ACLK);
      if (!ARESETN) begin
        m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_err = 1'b0;
        m_pv = 1'b0; m_bv = 1'b0;
        m_rq.delete();
      end else begin
        if (m_pv && m_cyc >= m_done) begin
          m_res = m_pend;
          m_pv  = 1'b0;
        end
        busy = m_pv;
        if (m_rq.size() != 0 && S_AXI_RREADY) void'(m_rq.pop_front());
        if (m_bv && S_AXI_BREADY) m_bv = 1'b0;
        if (S_AXI_ARREADY && S_AXI_ARVALID) begin
          case (S_AXI_ARADDR[3:2])
            2'd0: rv = m_a;
            2'd1: rv = m_b;
            2'd2: rv = {22'b0, m_err, busy, 5'b0, m_op};
            default: rv = m_res;
          endcase
          m_rq.push_back(rv);
        end
        if (S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID) begin
          m_bv = 1'b1;
          case (S_AXI_AWADDR[3:2])
            2'd0: m_a = strb_merge(m_a, S_AXI_WDATA, S_AXI_WSTRB);
            2'd1: m_b = strb_merge(m_b, S_AXI_WDATA, S_AXI_WSTRB);
            2'd2: begin
              if (S_AXI_WSTRB[0]) m_op = S_AXI_WDATA[2:0];
              if (S_AXI_WSTRB[3] && S_AXI_WDATA[31]) begin
                if (busy || (m_op == 3'd5 && !MUL_EN)) begin
                  m_err = 1'b1;
                end else begin
                  m_err  = 1'b0;
                  m_pend = alu_ref(m_a, m_b, m_op);
                  m_pv   = 1'b1;
                  m_done = m_cyc + ((m_op == 3'd5) ? 33 : 2);
                end
              end
            end
            default: ;
          endcase
        end
      end
      m_cyc++;
    end
  end

  // ---------------------------------------------------------------- compare process
  initial begin : compare
    forever begin
      @(negedge ACLK);
      if (chk_en) begin
        check("bvalid", S_AXI_BVALID, m_bv);
        check("rvalid", S_AXI_RVALID, m_rq.size() != 0);
        if (S_AXI_RVALID && m_rq.size() != 0) check("rdata", S_AXI_RDATA, m_rq[0]);
        if (S_AXI_BVALID) check("bresp", S_AXI_BRESP, 2'b00);
        if (S_AXI_RVALID) check("rresp", S_AXI_RRESP, 2'b00);
        check("awready_eq_wready", S_AXI_AWREADY, S_AXI_WREADY);
        if (S_AXI_AWREADY) check("awready_while_bvalid", S_AXI_BVALID, 1'b0);
      end
    end
  end

  // ---------------------------------------------------------------- bus tasks
  task automatic wait_awready();
    int n = 0;
    while (!S_AXI_AWREADY && n < 64) begin
      @(negedge ACLK);
      n++;
    end
    if (!S_AXI_AWREADY) check("awready_timeout", S_AXI_AWREADY, 1'b1);
  endtask

  task automatic wait_bvalid();
    int n = 0;
    while (!S_AXI_BVALID && n < 64) begin
      @(negedge ACLK);
      n++;
    end
    if (!S_AXI_BVALID) check("bvalid_timeout", S_AXI_BVALID, 1'b1);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int bdly);
    @(negedge ACLK);
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    wait_awready();
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    repeat (bdly) @(negedge ACLK);
    S_AXI_BREADY = 1'b1;
    wait_bvalid();
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input int rdly, output logic [31:0] data);
    int n = 0;
    @(negedge ACLK);
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && n < 64) begin
      @(negedge ACLK);
      n++;
    end
    if (!S_AXI_ARREADY) check("arready_timeout", S_AXI_ARREADY, 1'b1);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 64) begin
      @(negedge ACLK);
      n++;
    end
    if (!S_AXI_RVALID) check("rvalid_timeout", S_AXI_RVALID, 1'b1);
    data = S_AXI_RDATA;
    repeat (rdly) begin
      @(negedge ACLK);
      check("rdata_stable", S_AXI_RDATA, data);
    end
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic rd_expect(input logic [3:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] d;
    axi_read(addr, 0, d);
    check(name, d, exp);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [31:0] rd_d, wd;
  logic [3:0]  wa, ra, ws;

  initial begin : main
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", S_AXI_AWREADY, 1'b0);
    check("rst_wready",  S_AXI_WREADY,  1'b0);
    check("rst_bvalid",  S_AXI_BVALID,  1'b0);
    check("rst_arready", S_AXI_ARREADY, 1'b0);
    check("rst_rvalid",  S_AXI_RVALID,  1'b0);
    check("rst_rdata",   S_AXI_RDATA,   32'h0);
    check("rst_bresp",   S_AXI_BRESP,   2'b00);
    check("rst_rresp",   S_AXI_RRESP,   2'b00);
    ARESETN = 1'b1;
    chk_en  = 1'b1;

    // Basic register access.
    axi_write(4'h0, 32'd1, 4'hF, 0);
    axi_write(4'h4, 32'd2, 4'hF, 0);
    axi_write(4'h8, 32'd3, 4'hF, 0);
    axi_write(4'hC, 32'd4, 4'hF, 0);
    rd_expect(4'h0, 32'h1, "rd_op_a");
    rd_expect(4'h4, 32'h2, "rd_op_b");
    rd_expect(4'h8, 32'h3, "rd_ctrl");
    rd_expect(4'hC, 32'h0, "rd_result_ro");

    // ADD and SUB.
    axi_write(4'h0, 32'd5, 4'hF, 0);
    axi_write(4'h4, 32'd7, 4'hF, 0);
    axi_write(4'h8, 32'h8000_0000, 4'hF, 0);
    rd_expect(4'hC, 32'h0000_000C, "add_5_7");
    rd_expect(4'h8, 32'h0000_0000, "ctrl_after_add");
    axi_write(4'h0, 32'd3, 4'hF, 0);
    axi_write(4'h4, 32'd5, 4'hF, 0);
    axi_write(4'h8, 32'h8000_0001, 4'hF, 0);
    rd_expect(4'hC, 32'hFFFF_FFFE, "sub_3_5");

    // MUL, then START while busy.
    axi_write(4'h0, 32'h0001_0000, 4'hF, 0);
    axi_write(4'h4, 32'h0001_0001, 4'hF, 0);
    axi_write(4'h8, 32'h8000_0005, 4'hF, 0);
    if (MUL_EN) begin
      rd_expect(4'h8, 32'h0000_0105, "mul_busy");
      axi_write(4'h8, 32'h8000_0005, 4'hF, 0);
      rd_expect(4'h8, 32'h0000_0305, "start_while_busy");
      repeat (40) @(negedge ACLK);
      rd_expect(4'hC, 32'h0001_0000, "mul_result");
      rd_expect(4'h8, 32'h0000_0205, "err_sticky");
    end else begin
      rd_expect(4'h8, 32'h0000_0205, "mul_disabled_err");
      rd_expect(4'hC, 32'hFFFF_FFFE, "mul_disabled_result");
      axi_write(4'h8, 32'h8000_0005, 4'hF, 0);
      rd_expect(4'h8, 32'h0000_0205, "mul_disabled_err2");
    end
    axi_write(4'h8, 32'h8000_0000, 4'hF, 0);
    rd_expect(4'hC, 32'h0002_0001, "add_after_err");
    rd_expect(4'h8, 32'h0000_0000, "err_cleared");

    // Back-pressure: BREADY low with a second write pending.
    @(negedge ACLK);
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h11; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    wait_awready();
    @(negedge ACLK);
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h22;
    for (int i = 0; i < 10; i++) begin
      check("hold_bvalid", S_AXI_BVALID, 1'b1);
      check("hold_awready", S_AXI_AWREADY, 1'b0);
      check("hold_wready", S_AXI_WREADY, 1'b0);
      @(negedge ACLK);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    wait_awready();
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    wait_bvalid();
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    axi_read(4'h0, 10, rd_d);
    check("rready_hold_op_a", rd_d, 32'h11);
    rd_expect(4'h4, 32'h22, "second_write_op_b");

    // Partial strobe.
    axi_write(4'h0, 32'h0, 4'hF, 0);
    axi_write(4'h0, 32'hAABB_CCDD, 4'b0010, 0);
    rd_expect(4'h0, 32'h0000_CC00, "partial_strb");

    // RESULT read in the same cycle a START is accepted returns the old value.
    axi_write(4'h0, 32'd1, 4'hF, 0);
    axi_write(4'h4, 32'd1, 4'hF, 0);
    axi_write(4'h8, 32'h8000_0000, 4'hF, 0);
    rd_expect(4'hC, 32'h2, "add_1_1");
    axi_write(4'h0, 32'd5, 4'hF, 0);
    axi_write(4'h4, 32'd5, 4'hF, 0);
    fork
      axi_write(4'h8, 32'h8000_0000, 4'hF, 0);
      axi_read(4'hC, 0, rd_d);
    join
    check("result_old_on_start", rd_d, 32'h2);
    rd_expect(4'hC, 32'hA, "add_5_5");

    // Reset in the middle of an operation.
    axi_write(4'h8, 32'h8000_0005, 4'hF, 0);
    repeat (5) @(negedge ACLK);
    ARESETN = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    rd_expect(4'h8, 32'h0, "ctrl_after_reset");
    rd_expect(4'hC, 32'h0, "result_after_reset");
    rd_expect(4'h0, 32'h0, "op_a_after_reset");

    // Randomised traffic.
    for (int it = 0; it < 250; it++) begin
      int kind;
      kind = $urandom_range(0, 9);
      wa = {2'($urandom_range(0, 3)), 2'b00};
      ra = {2'($urandom_range(0, 3)), 2'b00};
      wd = $urandom;
      ws = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if (wa == 4'h8) begin
        wd[31]  = ($urandom_range(0, 1) == 1);
        wd[2:0] = 3'($urandom_range(0, 7));
        ws      = 4'hF;
      end
      if (kind < 5) begin
        axi_write(wa, wd, ws, $urandom_range(0, 3));
      end else if (kind < 8) begin
        axi_read(ra, $urandom_range(0, 3), rd_d);
      end else begin
        fork
          axi_write(wa, wd, ws, $urandom_range(0, 3));
          axi_read(ra, $urandom_range(0, 3), rd_d);
        join
      end
      repeat ($urandom_range(0, 5)) @(negedge ACLK);
    end

    repeat (40) @(negedge ACLK);
    rd_expect(4'h8, {22'b0, m_err, 1'b0, 5'b0, m_op}, "final_ctrl_idle");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
